// File: rtl/bcd_timer_param_pkg.sv
// Shared types and helpers for the parametrised BCD timer.
// FSM state encoding, BCD digit width, group value helpers.
package bcd_timer_param_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int BCD_W = 4;

    // Binary 0..99 to packed {tens,ones}.
    function automatic logic [2*BCD_W-1:0] to_bcd(input int v);
        logic [BCD_W-1:0] t;
        logic [BCD_W-1:0] o;
        t = BCD_W'(v / 10);
        o = BCD_W'(v % 10);
        return {t, o};
    endfunction

    // Legal group: ones digit is decimal and value below modulus.
    function automatic logic group_valid(
        input logic [2*BCD_W-1:0] g,
        input int                 modulus
    );
        logic [BCD_W-1:0] t;
        logic [BCD_W-1:0] o;
        t = g[2*BCD_W-1:BCD_W];
        o = g[BCD_W-1:0];
        return (o <= 4'd9) &&
               ((int'(t) * 10 + int'(o)) < modulus);
    endfunction

endpackage

// File: rtl/bcd_group_counter.sv
// One two-digit BCD up/down group wrapping at GROUP_MOD.
// Ports: clk, reset_n, ld/ld_val (load, overrides en),
//   en/up (step), q (count), q_next (next value),
//   carry_out (en while at the limit in the count direction).
module bcd_group_counter
    import bcd_timer_param_pkg::*;
#(
    parameter int GROUP_MOD = 60
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       ld,
    input  logic [7:0] ld_val,
    input  logic       en,
    input  logic       up,
    output logic [7:0] q,
    output logic [7:0] q_next,
    output logic       carry_out
);

    localparam logic [7:0] LIM = to_bcd(GROUP_MOD - 1);

    logic             at_lim;
    logic [BCD_W-1:0] tens;
    logic [BCD_W-1:0] ones;

    assign tens      = q[2*BCD_W-1:BCD_W];
    assign ones      = q[BCD_W-1:0];
    assign at_lim    = up ? (q == LIM) : (q == 8'h00);
    assign carry_out = en & at_lim;

    always_comb begin
        q_next = q;
        if (ld) begin
            q_next = ld_val;
        end else if (en) begin
            if (at_lim) begin
                q_next = up ? 8'h00 : LIM;
            end else if (up) begin
                if (ones == 4'd9)
                    q_next = {tens + 4'd1, 4'd0};
                else
                    q_next = {tens, ones + 4'd1};
            end else begin
                if (ones == 4'd0)
                    q_next = {tens - 4'd1, 4'd9};
                else
                    q_next = {tens, ones - 4'd1};
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            q <= 8'h00;
        else
            q <= q_next;
    end

endmodule

// File: rtl/bcd_timer_param.sv
// Multi-group cascaded BCD timer: up/down, load, start/pause,
// one-shot or auto-reload, prescaled or external tick.
// Ports: clk, reset_n, tick_in, load, load_bcd, start, pause,
//   up_mode, auto_reload -> count_bcd, running, done_pulse,
//   load_err (all outputs registered).
module bcd_timer_param
    import bcd_timer_param_pkg::*;
#(
    parameter int GROUPS    = 2,
    parameter int GROUP_MOD = 60,
    parameter int PRESCALE  = 100,
    parameter int EXT_TICK  = 0
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                tick_in,
    input  logic                load,
    input  logic [8*GROUPS-1:0] load_bcd,
    input  logic                start,
    input  logic                pause,
    input  logic                up_mode,
    input  logic                auto_reload,
    output logic [8*GROUPS-1:0] count_bcd,
    output logic                running,
    output logic                done_pulse,
    output logic                load_err
);

    localparam int W  = 8 * GROUPS;
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [7:0] LIM = to_bcd(GROUP_MOD - 1);

    state_t          state;
    state_t          state_nxt;
    logic [PW-1:0]   presc;
    logic [PW-1:0]   presc_nxt;
    logic            wrap_pend;
    logic            wrap_nxt;
    logic [W-1:0]    reload_q;
    logic [W-1:0]    grp_q;
    logic [W-1:0]    grp_nxt;
    logic [W-1:0]    grp_ld_val;
    logic [GROUPS-1:0] carry;
    logic            grp_ld;
    logic            load_ok;
    logic            presc_wrap;
    logic            tick;
    logic            go;
    logic            restart;
    logic            reload_tick;
    logic            nxt_term;
    logic            done_set;

    always_comb begin
        load_ok = load;
        for (int g = 0; g < GROUPS; g++) begin
            if (!group_valid(load_bcd[8*g +: 8], GROUP_MOD))
                load_ok = 1'b0;
        end
    end

    assign presc_wrap = (presc == PW'(PRESCALE - 1));
    // pause and load both freeze the tick in the cycle they arrive
    assign tick = (state == ST_RUN) & ~pause & ~load &
                  ((EXT_TICK != 0) ? tick_in : presc_wrap);
    assign go          = start & ~pause & ~load;
    assign restart     = go & (state == ST_DONE);
    assign reload_tick = tick & wrap_pend;

    // A carry out of the top group means the whole count already
    // sits at terminal: hold it instead of rolling over.
    assign grp_ld = load_ok | restart | reload_tick |
                    carry[GROUPS-1];

    always_comb begin
        grp_ld_val = grp_q;
        if (load_ok)
            grp_ld_val = load_bcd;
        else if (restart)
            grp_ld_val = reload_q;
        else if (reload_tick)
            grp_ld_val = up_mode ? '0 : reload_q;
    end

    for (genvar g = 0; g < GROUPS; g++) begin : g_grp
        logic en_g;
        if (g == 0) begin : g_lsb
            assign en_g = tick & ~wrap_pend;
        end else begin : g_up
            assign en_g = carry[g-1];
        end
        bcd_group_counter #(
            .GROUP_MOD (GROUP_MOD)
        ) u_grp (
            .clk       (clk),
            .reset_n   (reset_n),
            .ld        (grp_ld),
            .ld_val    (grp_ld_val[8*g +: 8]),
            .en        (en_g),
            .up        (up_mode),
            .q         (grp_q[8*g +: 8]),
            .q_next    (grp_nxt[8*g +: 8]),
            .carry_out (carry[g])
        );
    end

    always_comb begin
        nxt_term = 1'b1;
        for (int g = 0; g < GROUPS; g++) begin
            if (grp_nxt[8*g +: 8] != (up_mode ? LIM : 8'h00))
                nxt_term = 1'b0;
        end
    end

    // Covers both a step onto terminal and a tick while held there.
    assign done_set = tick & ~wrap_pend & nxt_term;

    always_comb begin
        state_nxt = state;
        presc_nxt = presc;
        wrap_nxt  = wrap_pend;
        if (load) begin
            if (load_ok) begin
                state_nxt = ST_IDLE;
                presc_nxt = '0;
                wrap_nxt  = 1'b0;
            end
        end else begin
            unique case (state)
                ST_IDLE, ST_PAUSE: begin
                    if (go)
                        state_nxt = ST_RUN;
                end
                ST_DONE: begin
                    if (go) begin
                        state_nxt = ST_RUN;
                        presc_nxt = '0;
                        wrap_nxt  = 1'b0;
                    end
                end
                ST_RUN: begin
                    if (pause) begin
                        state_nxt = ST_PAUSE;
                    end else begin
                        if (EXT_TICK == 0)
                            presc_nxt = presc_wrap ? '0 : presc + 1'b1;
                        if (tick) begin
                            if (wrap_pend)
                                wrap_nxt = 1'b0;
                            else if (done_set && auto_reload)
                                wrap_nxt = 1'b1;
                            else if (done_set)
                                state_nxt = ST_DONE;
                        end
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            presc      <= '0;
            wrap_pend  <= 1'b0;
            reload_q   <= '0;
            running    <= 1'b0;
            done_pulse <= 1'b0;
            load_err   <= 1'b0;
        end else begin
            state      <= state_nxt;
            presc      <= presc_nxt;
            wrap_pend  <= wrap_nxt;
            if (load_ok)
                reload_q <= load_bcd;
            running    <= (state_nxt == ST_RUN);
            done_pulse <= done_set;
            load_err   <= load & ~load_ok;
        end
    end

    assign count_bcd = grp_q;

endmodule

// File: tb/tb_bcd_timer_param.sv
// Directed bench for bcd_timer_param (mm:ss, prescale 4)
// plus an external-tick instance sharing the controls.
module tb_bcd_timer_param;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        tick_in;
    logic        load;
    logic [15:0] load_bcd;
    logic        start;
    logic        pause;
    logic        up_mode;
    logic        auto_reload;
    logic [15:0] count;
    logic        running;
    logic        done_pulse;
    logic        load_err;
    logic [15:0] x_count;
    logic        x_running;
    logic        x_done;
    logic        x_err;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int done_total = 0;
    int idle_total = 0;
    int consec = 0;
    logic prev_done = 1'b0;

    logic [15:0] exp_q[$];
    int          exp_gap[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (done_pulse) done_total++;
        if (done_pulse && prev_done) consec++;
        prev_done = done_pulse;
        if (!running) idle_total++;
    end

    bcd_timer_param #(
        .GROUPS(2), .GROUP_MOD(60),
        .PRESCALE(4), .EXT_TICK(0)
    ) u_dut (
        .clk(clk), .reset_n(reset_n),
        .tick_in(tick_in), .load(load),
        .load_bcd(load_bcd), .start(start),
        .pause(pause), .up_mode(up_mode),
        .auto_reload(auto_reload),
        .count_bcd(count), .running(running),
        .done_pulse(done_pulse), .load_err(load_err)
    );

    bcd_timer_param #(
        .GROUPS(2), .GROUP_MOD(60),
        .PRESCALE(4), .EXT_TICK(1)
    ) u_ext (
        .clk(clk), .reset_n(reset_n),
        .tick_in(tick_in), .load(load),
        .load_bcd(load_bcd), .start(start),
        .pause(pause), .up_mode(up_mode),
        .auto_reload(auto_reload),
        .count_bcd(x_count), .running(x_running),
        .done_pulse(x_done), .load_err(x_err)
    );

    task automatic check(string tag, logic [31:0] got,
                         logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_load(logic [15:0] v);
        load_bcd = v;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic push(logic [15:0] v, int gap);
        exp_q.push_back(v);
        exp_gap.push_back(gap);
    endtask

    task automatic ext_tick();
        tick_in = 1'b1;
        @(negedge clk);
        tick_in = 1'b0;
        @(negedge clk);
    endtask

    // Pops one expectation per observed change of count.
    task automatic run_sb(string tag);
        logic [15:0] prev;
        int t0;
        int waited;
        int g;
        prev = count;
        t0 = cyc;
        while (exp_q.size() > 0) begin
            waited = 0;
            while (count === prev && waited < 20) begin
                @(negedge clk);
                waited++;
            end
            if (count === prev) begin
                tests++;
                fails++;
                $error("FAIL %s timeout got=%0h exp=%0h",
                       tag, count, exp_q[0]);
                exp_q.delete();
                exp_gap.delete();
                break;
            end
            check(tag, {16'h0, count}, {16'h0, exp_q.pop_front()});
            g = exp_gap.pop_front();
            if (g > 0)
                check({tag, "_gap"}, cyc - t0, g);
            prev = count;
            t0 = cyc;
        end
    endtask

    initial begin
        int d0;
        int i0;
        reset_n = 1'b0;
        tick_in = 1'b0;
        load = 1'b0;
        load_bcd = 16'h0;
        start = 1'b0;
        pause = 1'b0;
        up_mode = 1'b0;
        auto_reload = 1'b0;
        step(3);
        check("rst_count", count, 16'h0000);
        check("rst_running", running, 1'b0);
        check("rst_done", done_pulse, 1'b0);
        check("rst_err", load_err, 1'b0);
        reset_n = 1'b1;
        step(2);

        // async reset mid-count
        do_load(16'h1234);
        do_start();
        step(2);
        check("t1_run", running, 1'b1);
        check("t1_cnt", count, 16'h1234);
        d0 = done_total;
        #2 reset_n = 1'b0;
        #1;
        check("t1_rst_cnt", count, 16'h0000);
        check("t1_rst_run", running, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        step(20);
        check("t1_idle_cnt", count, 16'h0000);
        check("t1_idle_run", running, 1'b0);
        check("t1_no_done", done_total - d0, 0);

        // one-shot down count
        d0 = done_total;
        do_load(16'h0003);
        do_start();
        push(16'h0002, 4);
        push(16'h0001, 4);
        push(16'h0000, 4);
        run_sb("t2");
        check("t2_done_now", done_pulse, 1'b1);
        step(1);
        check("t2_done_off", done_pulse, 1'b0);
        check("t2_stop", running, 1'b0);
        step(20);
        check("t2_hold", count, 16'h0000);
        check("t2_done_cnt", done_total - d0, 1);

        // cascade borrow/carry, up terminal
        do_load(16'h0100);
        do_start();
        push(16'h0059, 4);
        run_sb("t3_borrow");
        up_mode = 1'b1;
        do_load(16'h0059);
        do_start();
        push(16'h0100, 4);
        run_sb("t3_carry");
        do_load(16'h5958);
        do_start();
        push(16'h5959, 4);
        run_sb("t3_upterm");
        check("t3_done", done_pulse, 1'b1);
        step(1);
        check("t3_stop", running, 1'b0);
        step(8);
        check("t3_hold", count, 16'h5959);
        up_mode = 1'b0;

        // auto-reload
        auto_reload = 1'b1;
        do_load(16'h0002);
        do_start();
        d0 = done_total;
        i0 = idle_total;
        push(16'h0001, 4);
        push(16'h0000, 4);
        push(16'h0002, 4);
        push(16'h0001, 4);
        push(16'h0000, 4);
        run_sb("t4");
        step(2);
        check("t4_done_cnt", done_total - d0, 2);
        check("t4_no_idle", idle_total - i0, 0);
        check("t4_run", running, 1'b1);
        auto_reload = 1'b0;

        // pause holds the prescaler
        do_load(16'h0010);
        do_start();
        step(2);
        pause = 1'b1;
        @(negedge clk);
        pause = 1'b0;
        check("t5_paused", running, 1'b0);
        step(10);
        check("t5_hold", count, 16'h0010);
        do_start();
        push(16'h0009, 2);
        run_sb("t5_resume");
        start = 1'b1;
        pause = 1'b1;
        @(negedge clk);
        start = 1'b0;
        pause = 1'b0;
        check("t5_both", running, 1'b0);
        step(6);
        check("t5_both_cnt", count, 16'h0009);

        // load rejection and external tick
        do_load(16'h0012);
        do_load(16'h006A);
        check("t6_err_a", load_err, 1'b1);
        check("t6_cnt_a", count, 16'h0012);
        @(negedge clk);
        check("t6_err_off", load_err, 1'b0);
        do_load(16'h0060);
        check("t6_err_b", load_err, 1'b1);
        check("t6_cnt_b", count, 16'h0012);
        do_start();
        ext_tick();
        check("t6_ext_tick", x_count, 16'h0011);
        pause = 1'b1;
        @(negedge clk);
        pause = 1'b0;
        ext_tick();
        ext_tick();
        ext_tick();
        check("t6_ext_pause", x_count, 16'h0011);
        check("t6_ext_run", x_running, 1'b0);

        check("done_consec", consec, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

endmodule
